mem_alu_core: RTL and testbench
===============================

Name: mem_alu_core

Overview:
- Combined datapath primitive for the 8-bit accumulator CPU: a 256-byte single-port synchronous RAM with a shared bidirectional data bus, plus an independent combinational 8-bit ALU.
- The CPU sequencer drives the memory address register (MAR) onto addr.
- The sequencer feeds the AC and MBR registers into ALU operands A and B.
- The sequencer latches alu_out back into AC.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words (256).
- DATA_WIDTH, 8, RAM word width and ALU operand width.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  ADDR_WIDTH  RAM word address.
- data  inout  DATA_WIDTH  shared bus; the block drives it only during reads, otherwise high-Z.
- cs  in  1  chip select, active-high.
- we  in  1  write enable, active-high.
- oe  in  1  output enable, active-high.
- alu_a  in  DATA_WIDTH  ALU operand A (AC).
- alu_b  in  DATA_WIDTH  ALU operand B (MBR).
- alu_sel  in  4  ALU operation select.
- alu_out  out  DATA_WIDTH  ALU result.
- alu_carry  out  1  carry/borrow/shifted-out bit.
- alu_zero  out  1  high when alu_out == 0.

Behaviour:
- RAM write: at posedge clk, if cs & we, then mem[addr] <= data. The write succeeds regardless of oe.
- RAM read: at posedge clk, if cs & !we, then rdata <= mem[addr].
  - Latency is exactly 1 cycle: an address applied at edge N is visible on data after edge N+1.
  - rdata holds its value when the read condition is false.
- Bus drive: data = rdata when cs & oe & !we, else high-Z. The block never drives the bus while we=1.
- Reset (rst=1, asynchronous) clears rdata to 0 immediately. Memory contents are NOT cleared and survive reset, including a reset asserted mid-read or mid-write sequence. Writes are suppressed while rst=1.
- Address wrap: the address is full-width, so no out-of-range case exists. 0xFF is a valid last word.
- Memory contents are undefined (X) before the first write.
- ALU is purely combinational with no clock or reset dependence. Outputs settle the same cycle as the inputs. alu_zero is derived from alu_out for every op.
- alu_sel encoding (carry is 0 unless noted):
  - 0000 pass A
  - 0001 A+B; carry = bit 8 of the 9-bit sum
  - 0010 A-B; carry = borrow (A<B)
  - 0011 A&B
  - 0100 A|B
  - 0101 A^B
  - 0110 ~A
  - 0111 A<<1; carry = A[7]
  - 1000 A>>1 logical; carry = A[0]
  - 1001 A+1; carry on 0xFF
  - 1010 A-1; borrow on 0x00
  - 1011 pass B
  - 1100 ~(A&B)
  - 1101 ~(A|B)
  - 1110 ~(A^B)
  - 1111 (A==B) ? 1 : 0
- All arithmetic is modulo 2**DATA_WIDTH, unsigned.

Decomposition:
- Package mem_alu_pkg: the alu_sel opcode constants (ALU_PASSA, ALU_ADD, ALU_SUB, ... ALU_EQ) as a 4-bit enum, plus default widths.
- One sub-module, mem_alu_alu8: the combinational ALU, instantiated by mem_alu_core.
- RAM array and bus logic stay inline.

Test Plan:
- Load/readback: write 0x10 to addr 0x00 and 0x0C to addr 0x01. Then with cs=1, we=0, oe=1, apply addr 0x00 → data=0x10 one edge later; apply addr 0x01 → data=0x0C.
- Bus tri-state: oe=0, or cs=0, or we=1 → data is high-Z. A testbench driving 0x84 with we=1, oe=0 writes mem[0x10]=0x84 without contention.
- Reset mid-operation: write 0xF0 to 0x1E, read it back, then pulse rst between clock edges → rdata/data (oe=1) drops to 0x00 immediately. After release, a re-read of 0x1E returns 0xF0.
- ALU add: alu_sel=0001.
  - A=0x05, B=0x07 → alu_out=0x0C, carry=0, zero=0.
  - A=0xF0, B=0x20 → out=0x10, carry=1.
  - A=0xFF, B=0x01 → out=0x00, carry=1, zero=1.
- ALU sub/shift: alu_sel=0010, A=0x05, B=0x07 → out=0xFE, carry=1. alu_sel=0111, A=0x81 → out=0x02, carry=1.
- Program-style sequence: store 0x00 at 0x1A, read back to confirm 0x00, then ADD with B=0x05 → 0x05, then ADD with B=0x05 again → 0x0A, all with 1-cycle RAM latency.

Source files
------------

// File: rtl/mem_alu_pkg.sv
// Shared definitions for the accumulator CPU datapath primitive:
// ALU opcode encoding and default bus widths.
package mem_alu_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_PASSA = 4'b0000,
    ALU_ADD   = 4'b0001,
    ALU_SUB   = 4'b0010,
    ALU_AND   = 4'b0011,
    ALU_OR    = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_NOTA  = 4'b0110,
    ALU_SHL   = 4'b0111,
    ALU_SHR   = 4'b1000,
    ALU_INC   = 4'b1001,
    ALU_DEC   = 4'b1010,
    ALU_PASSB = 4'b1011,
    ALU_NAND  = 4'b1100,
    ALU_NOR   = 4'b1101,
    ALU_XNOR  = 4'b1110,
    ALU_EQ    = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/mem_alu_alu8.sv
// Purely combinational ALU: result, carry/borrow/shifted-out bit and zero flag
// all settle in the same cycle as the operands.
module mem_alu_alu8
  import mem_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            sel,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  localparam logic [DATA_WIDTH:0] ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

  alu_op_e               op;
  logic [DATA_WIDTH:0]   wide;

  assign op = alu_op_e'(sel);

  // Arithmetic runs one bit wider so the top bit is the carry or borrow out.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    wide   = '0;
    case (op)
      ALU_PASSA: result = a;
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      ALU_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOTA: result = ~a;
      ALU_SHL: begin
        result = {a[DATA_WIDTH-2:0], 1'b0};
        carry  = a[DATA_WIDTH-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DATA_WIDTH-1:1]};
        carry  = a[0];
      end
      ALU_INC: begin
        wide   = {1'b0, a} + ONE;
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      ALU_DEC: begin
        wide   = {1'b0, a} - ONE;
        result = wide[DATA_WIDTH-1:0];
        carry  = wide[DATA_WIDTH];
      end
      ALU_PASSB: result = b;
      ALU_NAND:  result = ~(a & b);
      ALU_NOR:   result = ~(a | b);
      ALU_XNOR:  result = ~(a ^ b);
      ALU_EQ:    result = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mem_alu_core.sv
// 256-byte single-port synchronous RAM on a shared tri-state bus, plus the
// independent combinational ALU used by the accumulator CPU sequencer.
module mem_alu_core
  import mem_alu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  input  logic [3:0]            alu_sel,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_carry,
  output logic                  alu_zero
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;

  // The array has no reset so its contents survive rst; writes are held off
  // while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && cs && we) begin
      mem[addr] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (cs && !we) begin
      rdata <= mem[addr];
    end
  end

  assign data = (cs && oe && !we) ? rdata : {DATA_WIDTH{1'bz}};

  mem_alu_alu8 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_out),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

endmodule

// File: tb/tb_mem_alu_core.sv
// Scoreboard bench for mem_alu_core: stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_alu_core;
  import mem_alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  wire  [7:0] data;
  logic       cs;
  logic       we;
  logic       oe;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       alu_zero;

  logic       drive_en;
  logic [7:0] drive_val;

  int vectors;
  int miscompares;

  typedef struct {
    bit         is_alu;
    string      name;
    logic [7:0] data;
    logic [7:0] out;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb_q[$];

  assign data = drive_en ? drive_val : 8'hzz;

  mem_alu_core #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data      (data),
    .cs        (cs),
    .we        (we),
    .oe        (oe),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: everything queued since the previous negedge is due now.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (e.is_alu) begin
          if (alu_out !== e.out || alu_carry !== e.c || alu_zero !== e.z) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%h c=%b z=%b, want out=%h c=%b z=%b",
                     e.name, alu_out, alu_carry, alu_zero, e.out, e.c, e.z);
          end
        end else if (data !== e.data) begin
          miscompares++;
          $display("[TB] FAIL %s: got data=%h, want data=%h", e.name, data, e.data);
        end
      end
    end
  end

  task automatic push_bus(input string name, input logic [7:0] d);
    exp_t e;
    e.is_alu = 1'b0;
    e.name   = name;
    e.data   = d;
    e.out    = '0;
    e.c      = 1'b0;
    e.z      = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic wait_check();
    @(negedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a;
    drive_en = 1'b1; drive_val = d;
    @(posedge clk);
    #1;
    drive_en = 1'b0;
    we = 1'b0;
  endtask

  task automatic mem_read(input logic [7:0] a, input logic [7:0] d, input string name);
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = a;
    @(posedge clk);
    #1;
    push_bus(name, d);
    wait_check();
  endtask

  // Bench drives a peer value; the bus must show it untouched by the DUT.
  task automatic peer_check(input logic c, input logic o, input logic w,
                            input logic [7:0] a, input string name);
    cs = c; oe = o; we = w; addr = a;
    drive_en = 1'b1; drive_val = 8'h30;
    push_bus(name, 8'h30);
    wait_check();
    drive_en = 1'b0;
    we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] out, input logic c, input logic z,
                                input string name);
    exp_t e;
    alu_sel = sel; alu_a = a; alu_b = b;
    e.is_alu = 1'b1;
    e.name   = name;
    e.data   = '0;
    e.out    = out;
    e.c      = c;
    e.z      = z;
    sb_q.push_back(e);
    wait_check();
  endtask

  task automatic check_output();
    @(negedge clk);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; cs = 1'b1; oe = 1'b1; we = 1'b0; addr = 8'h00;
    drive_en = 1'b0; drive_val = 8'h00;
    alu_a = 8'h00; alu_b = 8'h00; alu_sel = ALU_PASSA;
    #1;
    push_bus("reset_state", 8'h00);
    wait_check();
    rst = 1'b0;

    // Load / readback
    mem_write(8'h00, 8'h10);
    mem_write(8'h01, 8'h0C);
    mem_read(8'h00, 8'h10, "read_00");
    mem_read(8'h01, 8'h0C, "read_01");

    // Bus release (rdata holds 0x0C underneath)
    peer_check(1'b1, 1'b0, 1'b0, 8'h01, "hiz_oe0");
    peer_check(1'b0, 1'b1, 1'b0, 8'h01, "hiz_cs0");
    peer_check(1'b1, 1'b1, 1'b1, 8'hFF, "hiz_we1");
    mem_read(8'hFF, 8'h30, "read_ff");
    mem_write(8'h10, 8'h84);
    mem_read(8'h10, 8'h84, "read_10");

    // Reset mid-operation
    mem_write(8'h1E, 8'hF0);
    mem_read(8'h1E, 8'hF0, "read_1e");
    @(posedge clk);
    #2;
    rst = 1'b1;
    push_bus("reset_drop", 8'h00);
    wait_check();
    rst = 1'b0;
    rst = 1'b1;
    mem_write(8'h1E, 8'h55);
    rst = 1'b0;
    mem_read(8'h1E, 8'hF0, "reread_1e");

    // ALU directed vectors
    apply_stimulus(ALU_ADD,   8'h05, 8'h07, 8'h0C, 1'b0, 1'b0, "add_05_07");
    apply_stimulus(ALU_ADD,   8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, "add_f0_20");
    apply_stimulus(ALU_ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, "add_ff_01");
    apply_stimulus(ALU_SUB,   8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, "sub_05_07");
    apply_stimulus(ALU_SUB,   8'h07, 8'h05, 8'h02, 1'b0, 1'b0, "sub_07_05");
    apply_stimulus(ALU_SUB,   8'h05, 8'h05, 8'h00, 1'b0, 1'b1, "sub_equal");
    apply_stimulus(ALU_SHL,   8'h81, 8'h00, 8'h02, 1'b1, 1'b0, "shl_81");
    apply_stimulus(ALU_SHL,   8'h40, 8'h00, 8'h80, 1'b0, 1'b0, "shl_40");
    apply_stimulus(ALU_PASSA, 8'h5A, 8'h3C, 8'h5A, 1'b0, 1'b0, "passa");
    apply_stimulus(ALU_AND,   8'h5A, 8'h3C, 8'h18, 1'b0, 1'b0, "and");
    apply_stimulus(ALU_OR,    8'h5A, 8'h3C, 8'h7E, 1'b0, 1'b0, "or");
    apply_stimulus(ALU_XOR,   8'h5A, 8'h3C, 8'h66, 1'b0, 1'b0, "xor");
    apply_stimulus(ALU_NOTA,  8'h5A, 8'h3C, 8'hA5, 1'b0, 1'b0, "nota");
    apply_stimulus(ALU_SHR,   8'h5A, 8'h00, 8'h2D, 1'b0, 1'b0, "shr_5a");
    apply_stimulus(ALU_SHR,   8'h01, 8'h00, 8'h00, 1'b1, 1'b1, "shr_01");
    apply_stimulus(ALU_INC,   8'h5A, 8'h00, 8'h5B, 1'b0, 1'b0, "inc_5a");
    apply_stimulus(ALU_INC,   8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, "inc_ff");
    apply_stimulus(ALU_DEC,   8'h5A, 8'h00, 8'h59, 1'b0, 1'b0, "dec_5a");
    apply_stimulus(ALU_DEC,   8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, "dec_00");
    apply_stimulus(ALU_PASSB, 8'h5A, 8'h3C, 8'h3C, 1'b0, 1'b0, "passb");
    apply_stimulus(ALU_NAND,  8'h5A, 8'h3C, 8'hE7, 1'b0, 1'b0, "nand");
    apply_stimulus(ALU_NOR,   8'h5A, 8'h3C, 8'h81, 1'b0, 1'b0, "nor");
    apply_stimulus(ALU_XNOR,  8'h5A, 8'h3C, 8'h99, 1'b0, 1'b0, "xnor");
    apply_stimulus(ALU_EQ,    8'h5A, 8'h3C, 8'h00, 1'b0, 1'b1, "eq_diff");
    apply_stimulus(ALU_EQ,    8'h3C, 8'h3C, 8'h01, 1'b0, 1'b0, "eq_same");

    // Program-style sequence: AC accumulates from a stored zero
    mem_write(8'h1A, 8'h00);
    mem_read(8'h1A, 8'h00, "read_1a");
    apply_stimulus(ALU_ADD, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0, "prog_add1");
    apply_stimulus(ALU_ADD, 8'h05, 8'h05, 8'h0A, 1'b0, 1'b0, "prog_add2");

    check_output();
  end

endmodule
